uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit; legal values are 4 or more.
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: rx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 Port: data  output  8  last correctly received byte.
REQ-006 Port: valid  output  1  one-cycle pulse: data updated with a new good byte.
REQ-007 Port: frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-008 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 The block SHALL receive frames of 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1); there is no parity.
REQ-010 The block SHALL pass rx through a two-flop synchronizer; all logic uses only the synchronized value rx_s.
REQ-011 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-012 IDLE: a falling edge on rx_s (previous 1, current 0) SHALL move the FSM to START and clear the bit-period counter; otherwise the FSM stays in IDLE.
REQ-013 START: after CLKS_PER_BIT/2 cycles (integer division), the block SHALL sample rx_s.
  - If rx_s is 0: go to DATA, clear the counter and the bit index.
  - If rx_s is 1: glitch; return to IDLE with no output pulse.
REQ-014 DATA: the block SHALL sample rx_s every CLKS_PER_BIT cycles.
  - Each sample is shifted into bit[index] of an internal shift register, index 0..7.
  - After the sample at index 7, go to STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles, the block SHALL sample rx_s.
  - If rx_s is 1: load data from the shift register and pulse valid.
  - If rx_s is 0: pulse frame_err and leave data unchanged.
  - In both cases, return to IDLE.
REQ-016 Each pulse SHALL be asserted in the cycle immediately after the stop-bit sample and SHALL be high for exactly one cycle.
REQ-017 valid and frame_err SHALL never be high in the same cycle.
REQ-018 After a frame error, no new frame SHALL start until rx_s has returned to 1 and then falls again; this follows from the edge detection in REQ-012.
REQ-019 data SHALL hold its value between valid pulses; partial frames SHALL never appear on data.
REQ-020 The bit-period counter SHALL be $clog2(CLKS_PER_BIT)+1 bits wide and SHALL wrap to 0 on every sample point, so bit timing does not drift.
REQ-021 Back-to-back frames: a start edge detected in the IDLE cycle right after STOP SHALL be accepted, so there is no dead time beyond the synchronizer.
REQ-022 busy SHALL be high from the cycle after the start edge is detected until the cycle in which the FSM re-enters IDLE.

Reset
REQ-023 While reset is high, all outputs SHALL be: data=8'h00, valid=0, frame_err=0, busy=0.
REQ-024 While reset is high, the FSM SHALL be in IDLE, counters at 0, the shift register at 0, and the synchronizer flops and the edge-detect register at 1 (idle line).
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, with no valid or frame_err pulse.
REQ-026 After reset is released, reception SHALL resume only on a fresh falling edge of rx_s.

Verification
REQ-027 The bench SHALL cover these directed scenarios, all with CLKS_PER_BIT=16 and one bit = 16 clocks:
  - Send 8'hA5 with a good stop bit -> exactly one valid pulse, data=8'hA5, frame_err stays 0, busy low after the pulse.
  - Send 8'h00 then 8'hFF back-to-back (stop bit followed directly by the next start bit) -> two valid pulses, data=8'h00 then 8'hFF.
  - Send 8'h3C with the stop bit driven 0 -> one frame_err pulse, no valid, data keeps its prior value (8'h00 after reset); a following good 8'h81 frame -> valid, data=8'h81.
  - Drive rx low for 4 clocks, then high -> FSM returns to IDLE, no valid or frame_err; busy high for at most 8 cycles.
  - Assert reset at bit index 4 of a frame, release it, then send 8'h5A -> no pulse for the aborted frame; valid with data=8'h5A for the new one.
  - Latency check on the 8'hA5 frame -> valid rises 2+8+8*16+16+1 = 155 cycles (+/-1) after the rx falling edge.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Two-flop input synchronizer, falling-edge
//                start detection, mid-bit sampling driven by a bit-period
//                counter that restarts at every sample point.
//  Ports       : clk        system clock, rising edge
//                reset      asynchronous active-high reset
//                rx         serial input, idle high, asynchronous to clk
//                data[7:0]  last correctly received byte
//                valid      1-cycle pulse, data holds a new good byte
//                frame_err  1-cycle pulse, stop bit was sampled low
//                busy       high while the receiver is not idle
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    // Last count value before a sample point: half a bit for the start bit
    // (lands in the middle of the bit), a full bit for data and stop bits.
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] C_FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_rx_prev;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_busy;

    // Synchronizer and edge-detect history reset to the idle (high) level so
    // that leaving reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_rx_prev && !r_rx_s) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (r_cnt == C_HALF_LAST) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            // Line went back high before mid-start: glitch.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == C_FULL_LAST) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= r_rx_s;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == C_FULL_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (r_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx (CLKS_PER_BIT = 16). Frames
//                are sent as bit sequences; each sent frame predicts one
//                outcome (good byte or framing error) due 155 cycles after
//                the falling edge of its start bit, and a per-cycle compare
//                process matches DUT pulses and data against those outcomes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int CLKS = 16;
    localparam int LAT  = 2 + 8 + 8 * CLKS + CLKS + 1;  // 155

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         good;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         last_pulse_cyc = 0;
    logic [7:0] model_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            model_data = 8'h00;
            checks++;
            if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs: got data=%h valid=%b frame_err=%b busy=%b, need 00 0 0 0",
                         data, valid, frame_err, busy);
            end
        end else begin
            checks++;
            if (valid === 1'b1 && frame_err === 1'b1) begin
                failures++;
                $display("FAIL pulse_exclusive: valid and frame_err both high at cycle %0d", cyc);
            end
            if (valid === 1'b1 || frame_err === 1'b1) begin
                if (valid === 1'b1) n_valid++;
                if (frame_err === 1'b1) n_ferr++;
                last_pulse_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: valid=%b frame_err=%b at cycle %0d, need no pulse",
                             valid, frame_err, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (valid !== e.good || cyc < e.due - 1 || cyc > e.due + 1) begin
                        failures++;
                        $display("FAIL pulse_kind_time: got valid=%b at cycle %0d, need valid=%b at cycle %0d+/-1",
                                 valid, cyc, e.good, e.due);
                    end
                    if (e.good) model_data = e.b;
                end
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_after_frame: got busy=%b at pulse cycle %0d, need 0", busy, cyc);
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due + 1) begin
                checks++;
                failures++;
                $display("FAIL missing_pulse: no pulse by cycle %0d, need one at cycle %0d (byte %h good=%b)",
                         cyc, exp_q[0].due, exp_q[0].b, exp_q[0].good);
                void'(exp_q.pop_front());
            end
            checks++;
            if (data !== model_data) begin
                failures++;
                $display("FAIL data_hold: got data=%h at cycle %0d, need %h", data, cyc, model_data);
            end
        end
    end

    // All stimulus tasks start and end at posedge+#1.
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (CLKS) @(posedge clk);
        #1;
    endtask

    // Sends one frame. abort_bit in 0..7 asserts reset mid-way through that
    // data bit, which discards the frame's prediction.
    task automatic send(input logic [7:0] b, input logic stop, input int abort_bit,
                        output int fall_cyc);
        exp_t e;
        fall_cyc = cyc;
        e.b    = b;
        e.good = stop;
        e.due  = cyc + LAT;
        exp_q.push_back(e);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                rx = b[i];
                repeat (CLKS / 2) @(posedge clk);
                #1;
                reset = 1'b1;
                exp_q.delete();
                rx = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                reset = 1'b0;
                return;
            end
            hold_bit(b[i]);
        end
        hold_bit(stop);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d outcomes outstanding, need 0", exp_q.size());
        end
        idle(20);
    endtask

    task automatic check_lit(input string name, input int got, input int need);
        checks++;
        if (got != need) begin
            failures++;
            $display("FAIL %s: got %0d, need %0d", name, got, need);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(10);
    endtask

    initial begin
        #(10 * 50000);
        $display("FAIL watchdog: simulation still running at cycle %0d, need finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fall;
        int busy_cnt;
        @(posedge clk);
        #1;
        do_reset();

        // Good frame 8'hA5 plus latency.
        send(8'hA5, 1'b1, -1, fall);
        drain();
        check_lit("a5_data", int'(data), 8'hA5);
        check_lit("a5_valid_count", n_valid, 1);
        check_lit("a5_ferr_count", n_ferr, 0);
        checks++;
        if (last_pulse_cyc - fall < LAT - 1 || last_pulse_cyc - fall > LAT + 1) begin
            failures++;
            $display("FAIL a5_latency: got %0d cycles, need 155+/-1", last_pulse_cyc - fall);
        end
        check_lit("a5_busy_idle", int'(busy), 0);

        // Back-to-back 8'h00 then 8'hFF, no gap after the stop bit.
        send(8'h00, 1'b1, -1, fall);
        send(8'hFF, 1'b1, -1, fall);
        drain();
        check_lit("b2b_data", int'(data), 8'hFF);
        check_lit("b2b_valid_count", n_valid, 3);

        // Framing error on 8'h3C after reset, then good 8'h81.
        do_reset();
        send(8'h3C, 1'b0, -1, fall);
        idle(1);
        drain();
        check_lit("ferr_count", n_ferr, 1);
        check_lit("ferr_data_kept", int'(data), 8'h00);
        check_lit("ferr_no_valid", n_valid, 3);
        send(8'h81, 1'b1, -1, fall);
        drain();
        check_lit("after_ferr_data", int'(data), 8'h81);

        // 4-cycle glitch on the line.
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy_cnt < 1 || busy_cnt > 8) begin
            failures++;
            $display("FAIL glitch_busy: got %0d busy cycles, need 1..8", busy_cnt);
        end
        check_lit("glitch_valid_count", n_valid, 4);
        check_lit("glitch_ferr_count", n_ferr, 1);

        // Reset during data bit 4, then a fresh 8'h5A frame.
        send(8'hC3, 1'b1, 4, fall);
        idle(10);
        check_lit("abort_data", int'(data), 8'h00);
        send(8'h5A, 1'b1, -1, fall);
        drain();
        check_lit("post_abort_data", int'(data), 8'h5A);
        check_lit("post_abort_valid_count", n_valid, 5);
        check_lit("final_ferr_count", n_ferr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
